// File: rtl/adc_pedestal_frontend.sv
// Per-channel ADC conditioning: bit-flip removal, 2-stage registered pedestal
// subtraction with saturation, and a windowed pedestal measurement FSM.
module adc_pedestal_frontend #(
  parameter logic [12:0] BITFLIP  = 13'h0000,
  parameter int unsigned PED_LOG2 = 4
) (
  input  logic               clk357,
  input  logic               rst_n,
  input  logic [12:0]        data_in,
  input  logic               store_strb,
  input  logic               ped_cal,
  input  logic               ped_en,
  output logic signed [12:0] data_out,
  output logic               data_valid,
  output logic signed [12:0] ped_out,
  output logic               ped_busy,
  output logic               ped_done,
  output logic               ped_err,
  output logic               sat_flag
);

  localparam int DATA_W = 13;
  localparam int ACC_W  = DATA_W + PED_LOG2;
  localparam int CNT_W  = PED_LOG2 + 1;
  localparam logic [CNT_W-1:0]        CNT_FULL   = {1'b1, {PED_LOG2{1'b0}}};
  localparam logic signed [DATA_W:0]  SAT_MAX    = (DATA_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [DATA_W:0]  SAT_MIN    = ~SAT_MAX;
  localparam logic signed [ACC_W:0]   ROUND_HALF = (ACC_W+1)'(1 << (PED_LOG2-1));

  typedef enum logic [1:0] {IDLE, ARMED, ACC, DONE} ped_state_e;

  function automatic logic signed [DATA_W-1:0] sat_val(input logic signed [DATA_W:0] x);
    if (x > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return x[DATA_W-1:0];
  endfunction

  function automatic logic is_clipped(input logic signed [DATA_W:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  // Round half up, then divide by the sample count with an arithmetic shift.
  function automatic logic signed [DATA_W-1:0] round_ped(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;
    sum     = $signed({acc[ACC_W-1], acc}) + ROUND_HALF;
    shifted = sum >>> PED_LOG2;
    return shifted[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] s_p1_d, s_p1_q;
  logic                     vld_p1_d, vld_p1_q;
  logic signed [DATA_W-1:0] dout_p2_d, dout_p2_q;
  logic                     sat_p2_d, sat_p2_q;
  logic                     vld_p2_d, vld_p2_q;
  logic signed [DATA_W-1:0] ped_sub;
  logic signed [DATA_W:0]   diff_p2;
  logic signed [ACC_W-1:0]  s_p1_ext;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     v1_rise;

  ped_state_e               state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [DATA_W-1:0] ped_out_q;
  logic                     ped_busy_q, ped_done_q, ped_err_q;

  always_comb begin
    s_p1_d    = data_in ^ BITFLIP;
    vld_p1_d  = store_strb;
    ped_sub   = ped_en ? ped_out_q : '0;
    diff_p2   = $signed({s_p1_q[DATA_W-1], s_p1_q}) - $signed({ped_sub[DATA_W-1], ped_sub});
    dout_p2_d = sat_val(diff_p2);
    sat_p2_d  = is_clipped(diff_p2);
    vld_p2_d  = vld_p1_q;
    s_p1_ext  = $signed({{PED_LOG2{s_p1_q[DATA_W-1]}}, s_p1_q});
    cnt_inc   = cnt_q + CNT_W'(1);
    // vld_p2_q holds the previous cycle's v1, so this is the window's first sample.
    v1_rise   = vld_p1_q && !vld_p2_q;
  end

  // Stage 1 (input register) and stage 2 (subtract + saturate)
  always_ff @(posedge clk357 or negedge rst_n) begin
    if (!rst_n) begin
      s_p1_q    <= '0;
      vld_p1_q  <= 1'b0;
      dout_p2_q <= '0;
      sat_p2_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
    end else begin
      s_p1_q    <= s_p1_d;
      vld_p1_q  <= vld_p1_d;
      dout_p2_q <= dout_p2_d;
      sat_p2_q  <= sat_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  always_ff @(posedge clk357 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ped_out_q  <= '0;
      ped_busy_q <= 1'b0;
      ped_done_q <= 1'b0;
      ped_err_q  <= 1'b0;
    end else begin
      ped_done_q <= 1'b0;
      ped_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ped_cal) begin
            state_q    <= ARMED;
            ped_busy_q <= 1'b1;
          end
        end
        ARMED: begin
          if (v1_rise) begin
            acc_q   <= s_p1_ext;
            cnt_q   <= CNT_W'(1);
            state_q <= ACC;
          end
        end
        ACC: begin
          if (vld_p1_q) begin
            acc_q <= acc_q + s_p1_ext;
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              state_q    <= DONE;
              ped_busy_q <= 1'b0;
            end
          end else begin
            ped_err_q  <= 1'b1;
            ped_busy_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        DONE: begin
          ped_out_q  <= round_ped(acc_q);
          ped_done_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          ped_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = dout_p2_q;
  assign sat_flag   = sat_p2_q;
  assign data_valid = vld_p2_q;
  assign ped_out    = ped_out_q;
  assign ped_busy   = ped_busy_q;
  assign ped_done   = ped_done_q;
  assign ped_err    = ped_err_q;

endmodule

// File: tb/tb_adc_pedestal_frontend.sv
// Testbench for adc_pedestal_frontend: directed vector table, corner-case
// sequences and randomized stimulus against a window/average reference model.
module tb_adc_pedestal_frontend;

  localparam logic [12:0] BF = 13'h1685;
  localparam int PL = 4;
  localparam int NS = 1 << PL;

  logic              clk357 = 1'b0;
  logic              rst_n = 1'b1;
  logic [12:0]       data_in = '0;
  logic              store_strb = 1'b0;
  logic              ped_cal = 1'b0;
  logic              ped_en = 1'b0;
  logic signed [12:0] data_out;
  logic              data_valid;
  logic signed [12:0] ped_out;
  logic              ped_busy, ped_done, ped_err, sat_flag;

  adc_pedestal_frontend #(.BITFLIP(BF), .PED_LOG2(PL)) dut (
    .clk357(clk357), .rst_n(rst_n), .data_in(data_in), .store_strb(store_strb),
    .ped_cal(ped_cal), .ped_en(ped_en), .data_out(data_out), .data_valid(data_valid),
    .ped_out(ped_out), .ped_busy(ped_busy), .ped_done(ped_done), .ped_err(ped_err),
    .sat_flag(sat_flag)
  );

  always #5 clk357 = ~clk357;

  int n_pass = 0;
  int n_chk  = 0;
  int done_seen = 0;
  int err_seen  = 0;

  // Reference model state, expressed as sample values and a list of window samples.
  int m_s1, m_v1, m_dout, m_dv, m_sat, m_ped, m_busy, m_done, m_err, m_mode;
  int m_samp[$];

  typedef struct {
    int s;
    bit en;
    bit strb;
    int exp_out;
    int exp_sat;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sval(input logic [12:0] raw);
    logic [12:0] x;
    x = raw ^ BF;
    return int'($signed(x));
  endfunction

  function automatic logic [12:0] enc(input int s);
    logic [12:0] x;
    x = 13'(s);
    return x ^ BF;
  endfunction

  function automatic int avg_samples();
    int sum;
    sum = 0;
    foreach (m_samp[i]) sum += m_samp[i];
    return int'($floor((real'(sum) + NS / 2.0) / NS));
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_v1 = 0; m_dout = 0; m_dv = 0; m_sat = 0; m_ped = 0;
    m_busy = 0; m_done = 0; m_err = 0; m_mode = 0;
    m_samp.delete();
  endtask

  task automatic model_edge();
    int s1o, v1o, prevv, pedo, d;
    s1o = m_s1; v1o = m_v1; prevv = m_dv; pedo = m_ped;
    d = s1o - (ped_en ? pedo : 0);
    m_sat  = (d > 4095 || d < -4096) ? 1 : 0;
    m_dout = (d > 4095) ? 4095 : (d < -4096) ? -4096 : d;
    m_dv   = v1o;
    m_s1   = sval(data_in);
    m_v1   = store_strb;
    m_done = 0;
    m_err  = 0;
    case (m_mode)
      0: if (ped_cal) m_mode = 1;
      1: if (v1o == 1 && prevv == 0) begin
           m_samp = {s1o};
           m_mode = 2;
         end
      2: if (v1o == 1) begin
           m_samp.push_back(s1o);
           if (m_samp.size() == NS) m_mode = 3;
         end else begin
           m_err  = 1;
           m_mode = 0;
         end
      default: begin
        m_ped  = avg_samples();
        m_done = 1;
        m_mode = 0;
      end
    endcase
    m_busy = (m_mode == 1 || m_mode == 2) ? 1 : 0;
  endtask

  task automatic compare_all();
    chk("data_out", data_out, m_dout);
    chk("data_valid", data_valid, m_dv);
    chk("sat_flag", sat_flag, m_sat);
    chk("ped_out", ped_out, m_ped);
    chk("ped_busy", ped_busy, m_busy);
    chk("ped_done", ped_done, m_done);
    chk("ped_err", ped_err, m_err);
  endtask

  task automatic cyc();
    @(posedge clk357);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    compare_all();
    if (ped_done) done_seen++;
    if (ped_err) err_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic measure(input int a, input int b, input int len, output int dones);
    int d0;
    store_strb = 1'b0;
    repeat (3) cyc();
    ped_cal = 1'b1;
    cyc();
    ped_cal = 1'b0;
    d0 = done_seen;
    for (int i = 0; i < len; i++) begin
      data_in    = enc((i % 2) ? b : a);
      store_strb = 1'b1;
      cyc();
    end
    store_strb = 1'b0;
    repeat (4) cyc();
    dones = done_seen - d0;
  endtask

  initial begin
    int d, e0, ds0, run_left;

    // Expectations below assume ped_out = 3.
    tbl[0] = '{3,     1'b1, 1'b1, 0,     0};
    tbl[1] = '{-4096, 1'b1, 1'b1, -4096, 1};
    tbl[2] = '{4095,  1'b1, 1'b1, 4092,  0};
    tbl[3] = '{-4093, 1'b1, 1'b1, -4096, 0};
    tbl[4] = '{-4094, 1'b1, 1'b1, -4096, 1};
    tbl[5] = '{-2,    1'b0, 1'b1, -2,    0};
    tbl[6] = '{4095,  1'b0, 1'b0, 4095,  0};
    tbl[7] = '{0,     1'b1, 1'b0, -3,    0};

    model_reset();
    #2;
    do_reset();
    chk("reset_ped_out", ped_out, 0);
    chk("reset_data_out", data_out, 0);

    // Bit-flip path and fixed latency
    ped_en = 1'b0;
    data_in = enc(-2);
    store_strb = 1'b1;
    cyc();
    chk("lat1_valid", data_valid, 0);
    cyc();
    chk("bitflip_out", data_out, -2);
    chk("bitflip_valid", data_valid, 1);
    store_strb = 1'b0;
    cyc();
    chk("valid_tail", data_valid, 1);
    cyc();
    chk("valid_drop", data_valid, 0);

    // Pedestal of constant 3, then the table with ped_out = 3
    measure(3, 3, 40, d);
    chk("ped3_done_count", d, 1);
    chk("ped3_value", ped_out, 3);
    for (int i = 0; i < 8; i++) begin
      data_in = enc(tbl[i].s);
      store_strb = tbl[i].strb;
      ped_en = tbl[i].en;
      cyc();
      cyc();
      chk($sformatf("tbl%0d_out", i), data_out, tbl[i].exp_out);
      chk($sformatf("tbl%0d_sat", i), sat_flag, tbl[i].exp_sat);
      chk($sformatf("tbl%0d_valid", i), data_valid, int'(tbl[i].strb));
    end
    ped_en = 1'b0;
    store_strb = 1'b0;

    // Alternating 2/3 averages to 2.5, rounds up to 3
    measure(2, 3, 40, d);
    chk("ped_round_done", d, 1);
    chk("ped_round_value", ped_out, 3);

    // Saturation at both rails
    measure(100, 100, 40, d);
    chk("ped100_value", ped_out, 100);
    ped_en = 1'b1;
    data_in = enc(-4096);
    store_strb = 1'b1;
    cyc(); cyc();
    chk("sat_low_out", data_out, -4096);
    chk("sat_low_flag", sat_flag, 1);
    ped_en = 1'b0;
    measure(-5, -5, 40, d);
    chk("pedm5_value", ped_out, -5);
    ped_en = 1'b1;
    data_in = enc(4095);
    store_strb = 1'b1;
    cyc(); cyc();
    chk("sat_high_out", data_out, 4095);
    chk("sat_high_flag", sat_flag, 1);
    ped_en = 1'b0;

    // Short window aborts the measurement
    e0 = err_seen;
    measure(7, 7, 10, d);
    chk("abort_no_done", d, 0);
    chk("abort_err_pulses", err_seen - e0, 1);
    chk("abort_ped_kept", ped_out, -5);
    chk("abort_busy", ped_busy, 0);

    // Requests during ARMED and ACC are dropped
    store_strb = 1'b0;
    repeat (3) cyc();
    ped_cal = 1'b1; cyc(); ped_cal = 1'b0;
    cyc();
    ped_cal = 1'b1; cyc(); ped_cal = 1'b0;
    ds0 = done_seen;
    for (int i = 0; i < 40; i++) begin
      data_in = enc(9);
      store_strb = 1'b1;
      ped_cal = (i == 5);
      cyc();
    end
    ped_cal = 1'b0;
    store_strb = 1'b0;
    repeat (4) cyc();
    chk("ignore_one_done", done_seen - ds0, 1);
    chk("ignore_ped", ped_out, 9);
    chk("ignore_idle", ped_busy, 0);
    measure(-20, -21, 40, d);
    chk("fresh_done", d, 1);
    chk("fresh_ped_neg_round", ped_out, -20);

    // Asynchronous reset in the middle of accumulation
    store_strb = 1'b0;
    repeat (3) cyc();
    ped_cal = 1'b1; cyc(); ped_cal = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_in = enc(50);
      store_strb = 1'b1;
      cyc();
    end
    chk("midacc_busy", ped_busy, 1);
    ds0 = done_seen;
    do_reset();
    repeat (10) cyc();
    chk("postrst_ped", ped_out, 0);
    chk("postrst_busy", ped_busy, 0);
    chk("postrst_no_done", done_seen - ds0, 0);
    measure(50, 50, 40, d);
    chk("postrst_measure", ped_out, 50);

    // Randomized traffic against the reference model
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        store_strb = ~store_strb;
        run_left = store_strb ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 10));
      end
      run_left--;
      data_in = 13'($urandom);
      ped_en  = 1'($urandom);
      ped_cal = ($urandom_range(0, 19) == 0);
      cyc();
    end
    ped_cal = 1'b0;
    store_strb = 1'b0;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
